mdio_request_arbiter: RTL

Shares one EthernetMDIOTransceiver between NUM_REQ independent requesters, for example the management register interface, a link-status poller and a PHY init sequencer.
- Latches single-cycle read/write strobes per requester.
- Grants round-robin and issues one MDIO transaction at a time.
- Tracks transceiver busy to completion and returns read data and a done pulse to the owning requester.
- Sits in sys_clk between the requesters and the transceiver's phy_* / mgmt_busy_fwd ports.

---
 rtl/mdio_request_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdio_request_arbiter.sv
// Round-robin arbiter sharing one MDIO transceiver among NUM_REQ requesters.
// Define MDIO_ARB_TIMEOUT_EN to bound how long the transceiver may stay busy.
module mdio_request_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int BUSY_WAIT      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [5*NUM_REQ-1:0]  req_md_addr,
  input  logic [5*NUM_REQ-1:0]  req_reg_addr,
  input  logic [16*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    req_busy,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [NUM_REQ-1:0]    req_drop,
  output logic [15:0]           rd_data,
  output logic [4:0]            phy_md_addr,
  output logic [4:0]            phy_reg_addr,
  output logic [15:0]           phy_wr_data,
  output logic                  phy_reg_rd,
  output logic                  phy_reg_wr,
  input  logic [15:0]           phy_rd_data,
  input  logic                  mgmt_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > BUSY_WAIT) ? TIMEOUT_CYCLES : BUSY_WAIT;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      pend_q, pend_d;
  logic [NUM_REQ-1:0]      op_wr_q, op_wr_d;
  logic [5*NUM_REQ-1:0]    md_q, md_d;
  logic [5*NUM_REQ-1:0]    rg_q, rg_d;
  logic [16*NUM_REQ-1:0]   wd_q, wd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4:0]              phy_md_q, phy_md_d;
  logic [4:0]              phy_rg_q, phy_rg_d;
  logic [15:0]             phy_wd_q, phy_wd_d;
  logic                    phy_rd_q, phy_rd_d;
  logic                    phy_wr_q, phy_wr_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
  logic [NUM_REQ-1:0]      drop_q, drop_d;
  logic [15:0]             rd_data_q, rd_data_d;

  logic                    gnt_hit;
  logic [IW-1:0]           gnt_idx;
  logic                    fin;
  logic                    fin_err;

  // First pending slot at or after the pointer, with wrap-around.
  always_comb begin
    int j;
    j       = 0;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_hit && pend_q[j]) begin
        gnt_hit = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    pend_d    = pend_q;
    op_wr_d   = op_wr_q;
    md_d      = md_q;
    rg_d      = rg_q;
    wd_d      = wd_q;
    cnt_d     = cnt_q;
    phy_md_d  = phy_md_q;
    phy_rg_d  = phy_rg_q;
    phy_wd_d  = phy_wd_q;
    phy_rd_d  = 1'b0;
    phy_wr_d  = 1'b0;
    done_d    = '0;
    err_d     = '0;
    drop_d    = '0;
    rd_data_d = rd_data_q;
    fin       = 1'b0;
    fin_err   = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      drop_d[i] = ((req_rd[i] || req_wr[i]) && pend_q[i])
                || (req_rd[i] && req_wr[i]);
      if ((req_rd[i] || req_wr[i]) && !pend_q[i]) begin
        pend_d[i]         = 1'b1;
        op_wr_d[i]        = req_wr[i];
        md_d[5*i +: 5]    = req_md_addr[5*i +: 5];
        rg_d[5*i +: 5]    = req_reg_addr[5*i +: 5];
        wd_d[16*i +: 16]  = req_wr_data[16*i +: 16];
      end
    end

    unique case (state_q)
      IDLE: begin
        // Never start while the transceiver is still busy.
        if (gnt_hit && !mgmt_busy) begin
          gnt_d    = gnt_idx;
          ptr_d    = (gnt_idx == IW'(NUM_REQ - 1)) ?
                     '0 : gnt_idx + 1'b1;
          phy_md_d = md_q[5*gnt_idx +: 5];
          phy_rg_d = rg_q[5*gnt_idx +: 5];
          phy_wd_d = wd_q[16*gnt_idx +: 16];
          phy_wr_d = op_wr_q[gnt_idx];
          phy_rd_d = !op_wr_q[gnt_idx];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mgmt_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!mgmt_busy) fin = 1'b1;
`ifdef MDIO_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      COMPLETE: begin
        pend_d[gnt_q] = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d        = COMPLETE;
      done_d[gnt_q]  = 1'b1;
      err_d[gnt_q]   = fin_err;
      if (!fin_err && !op_wr_q[gnt_q]) rd_data_d = phy_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      pend_q    <= '0;
      op_wr_q   <= '0;
      md_q      <= '0;
      rg_q      <= '0;
      wd_q      <= '0;
      cnt_q     <= '0;
      phy_md_q  <= '0;
      phy_rg_q  <= '0;
      phy_wd_q  <= '0;
      phy_rd_q  <= 1'b0;
      phy_wr_q  <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      drop_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      pend_q    <= pend_d;
      op_wr_q   <= op_wr_d;
      md_q      <= md_d;
      rg_q      <= rg_d;
      wd_q      <= wd_d;
      cnt_q     <= cnt_d;
      phy_md_q  <= phy_md_d;
      phy_rg_q  <= phy_rg_d;
      phy_wd_q  <= phy_wd_d;
      phy_rd_q  <= phy_rd_d;
      phy_wr_q  <= phy_wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign req_busy     = pend_q;
  assign req_done     = done_q;
  assign req_err      = err_q;
  assign req_drop     = drop_q;
  assign rd_data      = rd_data_q;
  assign phy_md_addr  = phy_md_q;
  assign phy_reg_addr = phy_rg_q;
  assign phy_wr_data  = phy_wd_q;
  assign phy_reg_rd   = phy_rd_q;
  assign phy_reg_wr   = phy_wr_q;

endmodule
